// File: rtl/control_unit.sv
// Hardwired Moore control sequencer: three-step fetch followed by an opcode-specific execute
// sequence. Strobes decode only from the state register and the opcode latched at the end of T2.
module control_unit (
  input  logic        Clock,
  input  logic        clear,
  input  logic        Stop,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        Cout,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIin,
  output logic        LOin,
  output logic [4:0]  ALU_op,
  output logic        Run
);

  typedef enum logic [3:0] {
    StReset, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StHalt
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] op_q;
  logic       last_step;
  logic       is_rtype, is_imm, is_muldiv, is_unary, is_halt;

  // Register fields are consumed by the datapath, not by the sequencer.
  logic unused_ir;
  assign unused_ir = ^IR[26:0];

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      state_q <= StReset;
      op_q    <= 5'b00000;
    end else begin
      state_q <= state_d;
      // Freeze the opcode so later IR changes cannot disturb the instruction in flight.
      if (state_q == StT2) op_q <= IR[31:27];
    end
  end

  assign is_rtype  = (op_q >= 5'b00011) && (op_q <= 5'b01010);
  assign is_imm    = (op_q >= 5'b01011) && (op_q <= 5'b01101);
  assign is_muldiv = (op_q == 5'b01110) || (op_q == 5'b01111);
  assign is_unary  = (op_q == 5'b10000) || (op_q == 5'b10001);
  assign is_halt   = (op_q == 5'b11001);

  always_comb begin
    state_d   = state_q;
    last_step = 1'b0;
    PCout     = 1'b0;
    PCin      = 1'b0;
    IncPC     = 1'b0;
    MARin     = 1'b0;
    Read      = 1'b0;
    MDRin     = 1'b0;
    MDRout    = 1'b0;
    IRin      = 1'b0;
    Gra       = 1'b0;
    Grb       = 1'b0;
    Grc       = 1'b0;
    Rin       = 1'b0;
    Rout      = 1'b0;
    Cout      = 1'b0;
    Yin       = 1'b0;
    Zin       = 1'b0;
    Zlowout   = 1'b0;
    Zhighout  = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    ALU_op    = 5'b00000;
    Run       = 1'b0;

    case (state_q)
      StReset: state_d = StT0;
      StT0: begin
        Run     = 1'b1;
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        PCin    = 1'b1;
        state_d = StT1;
      end
      StT1: begin
        Run     = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        state_d = StT2;
      end
      StT2: begin
        Run     = 1'b1;
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = StT3;
      end
      StT3: begin
        Run = 1'b1;
        if (is_rtype || is_imm) begin
          Grb     = 1'b1;
          Rout    = 1'b1;
          Yin     = 1'b1;
          state_d = StT4;
        end else if (is_muldiv) begin
          Gra     = 1'b1;
          Rout    = 1'b1;
          Yin     = 1'b1;
          state_d = StT4;
        end else if (is_unary) begin
          Grb     = 1'b1;
          Rout    = 1'b1;
          Zin     = 1'b1;
          ALU_op  = op_q;
          state_d = StT4;
        end else if (is_halt) begin
          state_d = StHalt;
        end else begin
          last_step = 1'b1;
        end
      end
      StT4: begin
        Run = 1'b1;
        if (is_rtype) begin
          Grc     = 1'b1;
          Rout    = 1'b1;
          Zin     = 1'b1;
          ALU_op  = op_q;
          state_d = StT5;
        end else if (is_imm) begin
          Cout    = 1'b1;
          Zin     = 1'b1;
          state_d = StT5;
          if (op_q == 5'b01011)      ALU_op = 5'b00011;
          else if (op_q == 5'b01100) ALU_op = 5'b00101;
          else                       ALU_op = 5'b00110;
        end else if (is_muldiv) begin
          Grb     = 1'b1;
          Rout    = 1'b1;
          Zin     = 1'b1;
          ALU_op  = op_q;
          state_d = StT5;
        end else begin
          Zlowout   = 1'b1;
          Gra       = 1'b1;
          Rin       = 1'b1;
          last_step = 1'b1;
        end
      end
      StT5: begin
        Run     = 1'b1;
        Zlowout = 1'b1;
        if (is_muldiv) begin
          LOin    = 1'b1;
          state_d = StT6;
        end else begin
          Gra       = 1'b1;
          Rin       = 1'b1;
          last_step = 1'b1;
        end
      end
      StT6: begin
        Run       = 1'b1;
        Zhighout  = 1'b1;
        HIin      = 1'b1;
        last_step = 1'b1;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StReset;
    endcase

    if (last_step) state_d = Stop ? StHalt : StT0;
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: each task walks one instruction class cycle by cycle and
// compares the packed strobe/ALU_op/Run vector against hand-written expectations.
module tb_control_unit;

  logic        Clock = 1'b0;
  logic        clear = 1'b1;
  logic        Stop  = 1'b0;
  logic [31:0] IR    = 32'h0;
  logic PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Gra, Grb, Grc, Rin, Rout;
  logic Cout, Yin, Zin, Zlowout, Zhighout, HIin, LOin, Run;
  logic [4:0] ALU_op;

  int n_tests = 0;
  int n_fail  = 0;

  control_unit dut (
    .Clock(Clock), .clear(clear), .Stop(Stop), .IR(IR),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .Read(Read), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .Cout(Cout), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin),
    .LOin(LOin), .ALU_op(ALU_op), .Run(Run)
  );

  always #5 Clock = ~Clock;

  logic [25:0] obs;
  assign obs = {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Gra, Grb, Grc, Rin, Rout,
                Cout, Yin, Zin, Zlowout, Zhighout, HIin, LOin, ALU_op, Run};

  localparam logic [19:0] PCOUT = 20'h80000, PCIN = 20'h40000, INCPC = 20'h20000;
  localparam logic [19:0] MARIN = 20'h10000, READ = 20'h08000, MDRIN = 20'h04000;
  localparam logic [19:0] MDROUT = 20'h02000, IRIN = 20'h01000, GRA = 20'h00800;
  localparam logic [19:0] GRB = 20'h00400, GRC = 20'h00200, RIN = 20'h00100;
  localparam logic [19:0] ROUT = 20'h00080, COUT = 20'h00040, YIN = 20'h00020;
  localparam logic [19:0] ZIN = 20'h00010, ZLO = 20'h00008, ZHI = 20'h00004;
  localparam logic [19:0] HIIN = 20'h00002, LOIN = 20'h00001;

  localparam logic [25:0] F0   = {PCOUT | MARIN | INCPC | PCIN, 5'b00000, 1'b1};
  localparam logic [25:0] F1   = {READ | MDRIN, 5'b00000, 1'b1};
  localparam logic [25:0] F2   = {MDROUT | IRIN, 5'b00000, 1'b1};
  localparam logic [25:0] BY   = {GRB | ROUT | YIN, 5'b00000, 1'b1};
  localparam logic [25:0] WB   = {ZLO | GRA | RIN, 5'b00000, 1'b1};
  localparam logic [25:0] IDLE = {20'h0, 5'b00000, 1'b1};
  localparam logic [25:0] HALT = 26'h0;

  task automatic step();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  // Leaves the bench at a falling edge with the DUT in T0.
  task automatic restart(input logic [31:0] ir);
    IR    = ir;
    clear = 1'b1;
    @(negedge Clock);
    clear = 1'b0;
    step();
  endtask

  task automatic test_reset();
    clear = 1'b1;
    #2;
    n_tests++;
    if (obs !== HALT) begin
      n_fail++;
      $display("FAIL reset_async: got %h expected %h", obs, HALT);
    end
    step();
    n_tests++;
    if (obs !== HALT) begin
      n_fail++;
      $display("FAIL reset_held: got %h expected %h", obs, HALT);
    end
    clear = 1'b0;
    #1;
    n_tests++;
    if (obs !== HALT) begin
      n_fail++;
      $display("FAIL reset_before_edge: got %h expected %h", obs, HALT);
    end
    step();
    n_tests++;
    if (obs !== F0) begin
      n_fail++;
      $display("FAIL reset_to_t0: got %h expected %h", obs, F0);
    end
  endtask

  task automatic test_rtype();
    logic [31:0] irs [0:1];
    logic [4:0]  ops [0:1];
    logic [25:0] exp [0:6];
    irs = '{32'h28918000, 32'h50000000};
    ops = '{5'b00101, 5'b01010};
    for (int k = 0; k < 2; k++) begin
      exp = '{F0, F1, F2, BY, {GRC | ROUT | ZIN, ops[k], 1'b1}, WB, F0};
      restart(irs[k]);
      for (int i = 0; i < 7; i++) begin
        n_tests++;
        if (obs !== exp[i]) begin
          n_fail++;
          $display("FAIL rtype op%b step%0d: got %h expected %h", ops[k], i, obs, exp[i]);
        end
        step();
      end
    end
  endtask

  task automatic test_imm();
    logic [31:0] irs [0:1];
    logic [4:0]  alu [0:1];
    logic [25:0] exp [0:6];
    irs = '{32'h60000000, 32'h68000000};
    alu = '{5'b00101, 5'b00110};
    for (int k = 0; k < 2; k++) begin
      exp = '{F0, F1, F2, BY, {COUT | ZIN, alu[k], 1'b1}, WB, F0};
      restart(irs[k]);
      for (int i = 0; i < 7; i++) begin
        n_tests++;
        if (obs !== exp[i]) begin
          n_fail++;
          $display("FAIL imm k%0d step%0d: got %h expected %h", k, i, obs, exp[i]);
        end
        step();
      end
    end
  endtask

  // IR switches to a halt opcode once T3 is running; the mul must still finish unchanged.
  task automatic test_mul();
    logic [25:0] exp [0:7];
    exp = '{F0, F1, F2, {GRA | ROUT | YIN, 5'b00000, 1'b1}, {GRB | ROUT | ZIN, 5'b01110, 1'b1},
            {ZLO | LOIN, 5'b00000, 1'b1}, {ZHI | HIIN, 5'b00000, 1'b1}, F0};
    restart(32'h70000000);
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (obs !== exp[i]) begin
        n_fail++;
        $display("FAIL mul step%0d: got %h expected %h", i, obs, exp[i]);
      end
      if (i == 3) IR = 32'hC8000000;
      if (i < 7) step();
    end
  endtask

  // Continues straight from the T0 left by test_mul, now fetching the halt opcode.
  task automatic test_back_to_back();
    logic [25:0] exp [0:5];
    exp = '{F0, F1, F2, IDLE, HALT, HALT};
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (obs !== exp[i]) begin
        n_fail++;
        $display("FAIL b2b_halt step%0d: got %h expected %h", i, obs, exp[i]);
      end
      step();
    end
  endtask

  task automatic test_not();
    logic [25:0] exp [0:5];
    exp = '{F0, F1, F2, {GRB | ROUT | ZIN, 5'b10001, 1'b1}, WB, F0};
    restart(32'h88000000);
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (obs !== exp[i]) begin
        n_fail++;
        $display("FAIL not step%0d: got %h expected %h", i, obs, exp[i]);
      end
      step();
    end
  endtask

  task automatic test_nop_undef();
    logic [31:0] irs [0:2];
    logic [25:0] exp [0:5];
    irs = '{32'hF8000000, 32'hC0000000, 32'h00000000};
    exp = '{F0, F1, F2, IDLE, F0, F1};
    for (int k = 0; k < 3; k++) begin
      restart(irs[k]);
      for (int i = 0; i < 6; i++) begin
        n_tests++;
        if (obs !== exp[i]) begin
          n_fail++;
          $display("FAIL nop ir%h step%0d: got %h expected %h", irs[k], i, obs, exp[i]);
        end
        step();
      end
    end
  endtask

  // Stop rises in T1 and stays up; only the final write-back step may act on it.
  task automatic test_stop();
    logic [25:0] exp [0:5];
    exp = '{F0, F1, F2, BY, {GRC | ROUT | ZIN, 5'b00011, 1'b1}, WB};
    restart(32'h18000000);
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (obs !== exp[i]) begin
        n_fail++;
        $display("FAIL stop step%0d: got %h expected %h", i, obs, exp[i]);
      end
      if (i == 1) Stop = 1'b1;
      step();
    end
    for (int i = 0; i < 14; i++) begin
      if (i == 10) Stop = 1'b0;
      n_tests++;
      if (obs !== HALT) begin
        n_fail++;
        $display("FAIL stop_halt cycle%0d: got %h expected %h", i, obs, HALT);
      end
      step();
    end
  endtask

  task automatic test_clear_mid();
    restart(32'h18000000);
    for (int i = 0; i < 4; i++) step();
    n_tests++;
    if (obs !== {GRC | ROUT | ZIN, 5'b00011, 1'b1}) begin
      n_fail++;
      $display("FAIL clr_pre_t4: got %h expected %h", obs, {GRC | ROUT | ZIN, 5'b00011, 1'b1});
    end
    #2;
    clear = 1'b1;
    #1;
    n_tests++;
    if (obs !== HALT) begin
      n_fail++;
      $display("FAIL clr_async: got %h expected %h", obs, HALT);
    end
    @(negedge Clock);
    clear = 1'b0;
    step();
    n_tests++;
    if (obs !== F0) begin
      n_fail++;
      $display("FAIL clr_restart: got %h expected %h", obs, F0);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_imm();
    test_mul();
    test_back_to_back();
    test_not();
    test_nop_undef();
    test_stop();
    test_clear_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
